// File: rtl/fsm_reader.sv
`default_nettype none
// ============================================================================
// Module   : fsm_reader
// Brief    : Avalon-MM style read controller that fetches audio samples and
//            publishes the latest one on a held register with a 1-cycle strobe.
// Revision : 1.0 - initial release
// ============================================================================
module fsm_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  waitrequest,
  input  logic                  readdatavalid,
  input  logic [DATA_WIDTH-1:0] readdata,
  output logic                  read,
  output logic [DATA_WIDTH-1:0] audio_sample,
  output logic                  sample_strobe,
  output logic                  timeout,
  output logic [1:0]            state
);

  localparam int                 c_cnt_w    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_WAIT    = 2'd0,
    ST_COPY    = 2'd1,
    ST_SEND    = 2'd2,
    ST_ILLEGAL = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [c_cnt_w-1:0]    r_cnt;
  logic [c_cnt_w-1:0]    w_cnt_nxt;
  logic                  r_read;
  logic                  w_read_nxt;
  logic [DATA_WIDTH-1:0] r_sample;
  logic [DATA_WIDTH-1:0] w_sample_nxt;
  logic                  r_strobe;
  logic                  w_strobe_nxt;
  logic                  r_timeout;
  logic                  w_timeout_nxt;

  // Every output is a register; its next value is derived from the next state.
  always_comb begin
    w_state_nxt   = ST_WAIT;
    w_cnt_nxt     = '0;
    w_sample_nxt  = r_sample;
    w_timeout_nxt = 1'b0;
    case (r_state)
      ST_WAIT: w_state_nxt = waitrequest ? ST_WAIT : ST_COPY;
      ST_COPY: begin
        if (readdatavalid) begin
          w_sample_nxt = readdata;
          w_state_nxt  = ST_SEND;
        end else if (r_cnt == c_cnt_last) begin
          w_timeout_nxt = 1'b1;
          w_state_nxt   = ST_WAIT;
        end else begin
          w_cnt_nxt   = r_cnt + 1'b1;
          w_state_nxt = ST_COPY;
        end
      end
      ST_SEND: w_state_nxt = waitrequest ? ST_WAIT : ST_COPY;
      default: w_state_nxt = ST_WAIT;
    endcase
    w_read_nxt   = (w_state_nxt == ST_WAIT);
    w_strobe_nxt = (w_state_nxt == ST_SEND);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= ST_WAIT;
      r_cnt     <= '0;
      r_read    <= 1'b1;
      r_sample  <= '0;
      r_strobe  <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_read    <= w_read_nxt;
      r_sample  <= w_sample_nxt;
      r_strobe  <= w_strobe_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  assign read          = r_read;
  assign audio_sample  = r_sample;
  assign sample_strobe = r_strobe;
  assign timeout       = r_timeout;
  assign state         = r_state;

endmodule
`default_nettype wire

// File: tb/tb_fsm_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_fsm_reader
// Brief    : Scoreboard bench for fsm_reader (TIMEOUT = 8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fsm_reader;

  localparam int c_dw = 16;
  localparam int c_to = 8;
  localparam logic [1:0] c_wait = 2'd0;
  localparam logic [1:0] c_copy = 2'd1;
  localparam logic [1:0] c_send = 2'd2;

  logic            clk = 1'b0;
  logic            reset;
  logic            waitrequest;
  logic            readdatavalid;
  logic [c_dw-1:0] readdata;
  logic            read;
  logic [c_dw-1:0] audio_sample;
  logic            sample_strobe;
  logic            timeout;
  logic [1:0]      state;

  int n_cmp = 0;
  int n_bad = 0;
  logic [c_dw-1:0] exp_q[$];
  logic [c_dw-1:0] last_sample;

  fsm_reader #(.DATA_WIDTH(c_dw), .TIMEOUT(c_to)) dut (
    .clk           (clk),
    .reset         (reset),
    .waitrequest   (waitrequest),
    .readdatavalid (readdatavalid),
    .readdata      (readdata),
    .read          (read),
    .audio_sample  (audio_sample),
    .sample_strobe (sample_strobe),
    .timeout       (timeout),
    .state         (state)
  );

  always #5 clk = ~clk;

  // Advance one edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset         = 1'b0;
    waitrequest   = 1'bx;
    readdatavalid = 1'bx;
    readdata      = 'x;
    repeat (3) step();
    waitrequest   = 1'b1;
    readdatavalid = 1'b0;
    readdata      = '0;
    step();
    n_cmp++;
    if ({state, read, audio_sample, sample_strobe, timeout} !== {c_wait, 1'b1, 16'h0000, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_values: got st=%0d rd=%b smp=%h stb=%b to=%b, want st=0 rd=1 smp=0000 stb=0 to=0",
               state, read, audio_sample, sample_strobe, timeout);
    end
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      n_cmp++;
      if ({state, read, audio_sample, sample_strobe} !== {c_wait, 1'b1, 16'h0000, 1'b0}) begin
        n_bad++;
        $display("FAIL reset_idle[%0d]: got st=%0d rd=%b smp=%h stb=%b, want st=0 rd=1 smp=0000 stb=0",
                 i, state, read, audio_sample, sample_strobe);
      end
    end
  endtask

  task automatic test_single_read();
    logic [c_dw-1:0] exp;
    waitrequest = 1'b0;
    step();
    n_cmp++;
    if ({state, read} !== {c_copy, 1'b0}) begin
      n_bad++;
      $display("FAIL enter_copy: got st=%0d rd=%b, want st=1 rd=0", state, read);
    end
    // waitrequest high during COPY must not block the capture.
    waitrequest   = 1'b1;
    readdatavalid = 1'b1;
    readdata      = 16'h5555;
    exp_q.push_back(readdata);
    step();
    exp = exp_q.pop_front();
    n_cmp++;
    if ({state, sample_strobe, audio_sample} !== {c_send, 1'b1, exp}) begin
      n_bad++;
      $display("FAIL capture_5555: got st=%0d stb=%b smp=%h, want st=2 stb=1 smp=%h",
               state, sample_strobe, audio_sample, exp);
    end
    last_sample = exp;
  endtask

  task automatic test_send_to_wait();
    readdatavalid = 1'b0;
    step();
    n_cmp++;
    if ({state, read, sample_strobe, audio_sample} !== {c_wait, 1'b1, 1'b0, last_sample}) begin
      n_bad++;
      $display("FAIL send_to_wait: got st=%0d rd=%b stb=%b smp=%h, want st=0 rd=1 stb=0 smp=%h",
               state, read, sample_strobe, audio_sample, last_sample);
    end
    readdatavalid = 1'b1;
    readdata      = 16'h1234;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if ({state, sample_strobe, audio_sample} !== {c_wait, 1'b0, last_sample}) begin
        n_bad++;
        $display("FAIL wait_ignores_rdv[%0d]: got st=%0d stb=%b smp=%h, want st=0 stb=0 smp=%h",
                 i, state, sample_strobe, audio_sample, last_sample);
      end
    end
    readdatavalid = 1'b0;
  endtask

  task automatic test_stream();
    logic [1:0]      ms;
    logic [c_dw-1:0] exp;
    int              strobes;
    ms      = c_wait;
    strobes = 0;
    waitrequest   = 1'b0;
    readdatavalid = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      readdata = 16'(i);
      if (ms == c_copy) exp_q.push_back(readdata);
      case (ms)
        c_wait:  ms = c_copy;
        c_copy:  ms = c_send;
        default: ms = c_copy;
      endcase
      step();
      n_cmp++;
      if ({state, sample_strobe} !== {ms, ms == c_send}) begin
        n_bad++;
        $display("FAIL stream_state[%0d]: got st=%0d stb=%b, want st=%0d stb=%b",
                 i, state, sample_strobe, ms, ms == c_send);
      end
      if (sample_strobe === 1'b1) begin
        strobes++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL stream_extra_strobe[%0d]: got smp=%h, want no strobe", i, audio_sample);
        end else begin
          exp = exp_q.pop_front();
          last_sample = exp;
          n_cmp++;
          if (audio_sample !== exp) begin
            n_bad++;
            $display("FAIL stream_data[%0d]: got smp=%h, want %h", i, audio_sample, exp);
          end
        end
      end
    end
    n_cmp++;
    if (strobes != 10) begin
      n_bad++;
      $display("FAIL stream_rate: got %0d strobes, want 10", strobes);
    end
    waitrequest   = 1'b1;
    readdatavalid = 1'b0;
    step();
    n_cmp++;
    if ({state, audio_sample} !== {c_wait, last_sample}) begin
      n_bad++;
      $display("FAIL stream_end: got st=%0d smp=%h, want st=0 smp=%h", state, audio_sample, last_sample);
    end
  endtask

  task automatic test_timeout();
    waitrequest   = 1'b0;
    readdatavalid = 1'b0;
    step();
    waitrequest = 1'b1;
    // The entry edge above starts COPY cycle 1; cycle 8 ends in the abandon.
    for (int i = 1; i <= c_to; i++) begin
      step();
      if (i < c_to) begin
        n_cmp++;
        if ({state, timeout} !== {c_copy, 1'b0}) begin
          n_bad++;
          $display("FAIL timeout_wait[%0d]: got st=%0d to=%b, want st=1 to=0", i, state, timeout);
        end
      end else begin
        n_cmp++;
        if ({state, timeout, read, audio_sample} !== {c_wait, 1'b1, 1'b1, last_sample}) begin
          n_bad++;
          $display("FAIL timeout_fire: got st=%0d to=%b rd=%b smp=%h, want st=0 to=1 rd=1 smp=%h",
                   state, timeout, read, audio_sample, last_sample);
        end
      end
    end
    step();
    n_cmp++;
    if ({state, timeout} !== {c_wait, 1'b0}) begin
      n_bad++;
      $display("FAIL timeout_pulse_len: got st=%0d to=%b, want st=0 to=0", state, timeout);
    end
  endtask

  task automatic test_reset_mid();
    waitrequest = 1'b0;
    step();
    reset         = 1'b0;
    readdatavalid = 1'b1;
    readdata      = 16'hABCD;
    step();
    n_cmp++;
    if ({state, read, sample_strobe, audio_sample} !== {c_wait, 1'b1, 1'b0, 16'h0000}) begin
      n_bad++;
      $display("FAIL reset_in_copy: got st=%0d rd=%b stb=%b smp=%h, want st=0 rd=1 stb=0 smp=0000",
               state, read, sample_strobe, audio_sample);
    end
    reset         = 1'b1;
    waitrequest   = 1'b1;
    readdatavalid = 1'b0;
    step();
    n_cmp++;
    if ({state, sample_strobe, audio_sample} !== {c_wait, 1'b0, 16'h0000}) begin
      n_bad++;
      $display("FAIL after_reset_mid: got st=%0d stb=%b smp=%h, want st=0 stb=0 smp=0000",
               state, sample_strobe, audio_sample);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    end
  endtask

  initial begin
    last_sample = '0;
    test_reset();
    test_single_read();
    test_send_to_wait();
    test_stream();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
